// File: rtl/gb_timer_if.sv
// CPU data-bus slave interface for the memory-mapped timer.
// Fields: addr, wdata, read_en, write_en from the CPU; rdata back.
interface GB_Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        read_en;
    logic        write_en;
    logic [7:0]  rdata;

    modport Slave_side (
        input  addr,
        input  wdata,
        input  read_en,
        input  write_en,
        output rdata
    );

    modport Master_side (
        output addr,
        output wdata,
        output read_en,
        output write_en,
        input  rdata
    );
endinterface

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer at FF04-FF07, one clk per T-cycle.
// Ports: clk, reset (sync, active-high), bus (GB_Bus_if.Slave_side),
// timer_req (one-clk IF bit 2 pulse), apu_div_tick (only when
// GB_TIMER_APU_DIV_TICK_EN is defined: 512 Hz frame-sequencer pulse).
module gb_timer #(
    parameter logic [15:0] DIV_RESET_VALUE = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    GB_Bus_if.Slave_side   bus,
    output logic           timer_req
`ifdef GB_TIMER_APU_DIV_TICK_EN
    ,
    output logic           apu_div_tick
`endif
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] OVF_DELAY = 2'd1;
    localparam logic [1:0] RELOAD    = 2'd2;

    logic [15:0] sys_cnt;
    logic [15:0] sys_next;
    logic [7:0]  tima;
    logic [7:0]  tima_inc;
    logic [7:0]  tma;
    logic [7:0]  tma_next;
    logic [2:0]  tac;
    logic [2:0]  tac_next;
    logic [1:0]  state;
    logic [1:0]  dly;
    logic        tick_q;
    logic        tick_now;
    logic        tap;
    logic        inc;
    logic        ovf;

    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;
    logic        rd_div;
    logic        rd_tima;
    logic        rd_tma;
    logic        rd_tac;

    always_comb begin
        wr_div  = bus.write_en && (bus.addr == 16'hFF04);
        wr_tima = bus.write_en && (bus.addr == 16'hFF05);
        wr_tma  = bus.write_en && (bus.addr == 16'hFF06);
        wr_tac  = bus.write_en && (bus.addr == 16'hFF07);
        rd_div  = bus.read_en && (bus.addr == 16'hFF04);
        rd_tima = bus.read_en && (bus.addr == 16'hFF05);
        rd_tma  = bus.read_en && (bus.addr == 16'hFF06);
        rd_tac  = bus.read_en && (bus.addr == 16'hFF07);
    end

    // Edge detection compares the tap as it will be after this edge
    // against the tap as it is now, so DIV and TAC writes that drop
    // the tap produce an increment on the same edge as the write.
    always_comb begin
        sys_next = wr_div ? 16'h0000 : sys_cnt + 16'd1;
        tac_next = wr_tac ? bus.wdata[2:0] : tac;
        tma_next = wr_tma ? bus.wdata : tma;
        tap      = 1'b0;
        unique case (tac_next[1:0])
            2'b00: tap = sys_next[9];
            2'b01: tap = sys_next[3];
            2'b10: tap = sys_next[5];
            2'b11: tap = sys_next[7];
            default: tap = 1'b0;
        endcase
        tick_now = tap & tac_next[2];
        inc      = tick_q & ~tick_now;
        tima_inc = tima + 8'd1;
        ovf      = inc && (tima == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sys_cnt   <= DIV_RESET_VALUE;
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            state     <= RUN;
            dly       <= 2'd0;
            tick_q    <= 1'b0;
            timer_req <= 1'b0;
        end else begin
            sys_cnt   <= sys_next;
            tac       <= tac_next;
            tma       <= tma_next;
            tick_q    <= tick_now;
            timer_req <= 1'b0;
            unique case (state)
                RUN: begin
                    if (wr_tima) begin
                        tima <= bus.wdata;
                    end else if (inc) begin
                        tima <= tima_inc;
                        if (ovf) begin
                            state <= OVF_DELAY;
                            dly   <= 2'd3;
                        end
                    end
                end
                OVF_DELAY: begin
                    if (wr_tima) begin
                        // CPU write cancels the pending reload/irq
                        tima  <= bus.wdata;
                        state <= RUN;
                    end else if (dly == 2'd0) begin
                        tima      <= tma_next;
                        timer_req <= 1'b1;
                        state     <= RELOAD;
                    end else begin
                        dly <= dly - 2'd1;
                        if (inc) begin
                            tima <= tima_inc;
                            if (ovf) begin
                                dly <= 2'd3;
                            end
                        end
                    end
                end
                RELOAD: begin
                    // TIMA writes are dropped; TMA writes land in both
                    state <= RUN;
                    if (wr_tma) begin
                        tima <= bus.wdata;
                    end else if (inc) begin
                        tima <= tima_inc;
                        if (ovf) begin
                            state <= OVF_DELAY;
                            dly   <= 2'd3;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef GB_TIMER_APU_DIV_TICK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            apu_div_tick <= 1'b0;
        end else begin
            apu_div_tick <= sys_cnt[12] & ~sys_next[12];
        end
    end
`endif

    always_comb begin
        bus.rdata = 8'h00;
        unique case (1'b1)
            rd_div:  bus.rdata = sys_cnt[15:8];
            rd_tima: bus.rdata = tima;
            rd_tma:  bus.rdata = tma;
            rd_tac:  bus.rdata = {5'b11111, tac};
            default: bus.rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer: vector table plus hand-written
// sequences for DIV wrap, APU tick and reset during overflow delay.
module tb_gb_timer;

    logic clk;
    logic reset;
    logic timer_req;
`ifdef GB_TIMER_APU_DIV_TICK_EN
    logic apu_div_tick;
`endif

    GB_Bus_if bus_if ();

    gb_timer #(.DIV_RESET_VALUE(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .timer_req (timer_req)
`ifdef GB_TIMER_APU_DIV_TICK_EN
        ,
        .apu_div_tick (apu_div_tick)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        int          adv;
        bit          ren;
        logic [15:0] raddr;
        logic [7:0]  exp_rd;
        logic        exp_req;
    } vec_t;

    vec_t vq[$];
    int checks;
    int failures;

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        bus_if.addr     = a;
        bus_if.wdata    = d;
        bus_if.write_en = 1'b1;
        @(posedge clk);
        #1;
        bus_if.write_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input bit en,
                          output logic [7:0] d);
        bus_if.addr    = a;
        bus_if.read_en = en;
        #1;
        d = bus_if.rdata;
        bus_if.read_en = 1'b0;
    endtask

    task automatic add(input bit wr, input logic [15:0] wa,
                       input logic [7:0] wd, input int n, input bit ren,
                       input logic [15:0] ra, input logic [7:0] er,
                       input logic eq);
        vq.push_back('{wr, wa, wd, n, ren, ra, er, eq});
    endtask

    logic [7:0] rd;
    int first_tick;
    int tick_cnt;
    bit prev_tick;
    bit wide_tick;

    initial begin
        checks   = 0;
        failures = 0;
        bus_if.addr     = 16'h0000;
        bus_if.wdata    = 8'h00;
        bus_if.read_en  = 1'b0;
        bus_if.write_en = 1'b0;
        reset = 1'b1;

        // overflow / reload with TAC=05, TMA=AB (t = edges since DIV write)
        add(1, 16'hFF06, 8'hAB, 0, 1, 16'hFF06, 8'hAB, 1'b0);
        add(1, 16'hFF05, 8'hFE, 0, 1, 16'hFF05, 8'hFE, 1'b0);
        add(1, 16'hFF04, 8'h5A, 0, 1, 16'hFF04, 8'h00, 1'b0);
        add(1, 16'hFF07, 8'h05, 0, 1, 16'hFF07, 8'hFD, 1'b0);
        add(0, 16'h0000, 8'h00, 14, 1, 16'hFF05, 8'hFE, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'hFF, 1'b0);
        add(0, 16'h0000, 8'h00, 15, 1, 16'hFF05, 8'hFF, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'hAB, 1'b1);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'hAB, 1'b0);
        // cancel: overflow at t=64, TIMA write at t=66
        add(1, 16'hFF05, 8'hFE, 0, 1, 16'hFF05, 8'hFE, 1'b0);
        add(0, 16'h0000, 8'h00, 25, 1, 16'hFF05, 8'hFF, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h00, 1'b0);
        add(1, 16'hFF05, 8'h42, 0, 1, 16'hFF05, 8'h42, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h42, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h42, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h42, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'h42, 1'b0);
        // DIV write drops tap bit 9 -> TIMA increments
        add(1, 16'hFF07, 8'h04, 0, 1, 16'hFF07, 8'hFC, 1'b0);
        add(0, 16'h0000, 8'h00, 441, 1, 16'hFF05, 8'h42, 1'b0);
        add(1, 16'hFF05, 8'h10, 0, 1, 16'hFF05, 8'h10, 1'b0);
        add(1, 16'hFF04, 8'hFF, 0, 1, 16'hFF05, 8'h11, 1'b0);
        add(0, 16'h0000, 8'h00, 0, 1, 16'hFF04, 8'h00, 1'b0);
        // misc reads (u = edges since second DIV write)
        add(1, 16'hFF07, 8'h05, 0, 1, 16'hFF07, 8'hFD, 1'b0);
        add(0, 16'h0000, 8'h00, 0, 1, 16'hFF08, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 0, 0, 16'hFF05, 8'h00, 1'b0);
        add(1, 16'hFF03, 8'h99, 0, 1, 16'hFF05, 8'h11, 1'b0);
        // TMA write in the RELOAD clk
        add(1, 16'hFF05, 8'hFF, 0, 1, 16'hFF05, 8'hFF, 1'b0);
        add(0, 16'h0000, 8'h00, 16, 1, 16'hFF05, 8'h00, 1'b0);
        add(0, 16'h0000, 8'h00, 1, 1, 16'hFF05, 8'hAB, 1'b1);
        add(1, 16'hFF06, 8'h77, 0, 1, 16'hFF05, 8'h77, 1'b0);
        add(0, 16'h0000, 8'h00, 0, 1, 16'hFF06, 8'h77, 1'b0);
        // set up overflow at u=32 for the reset test
        add(1, 16'hFF05, 8'hFF, 0, 1, 16'hFF05, 8'hFF, 1'b0);
        add(0, 16'h0000, 8'h00, 10, 1, 16'hFF05, 8'h00, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        bus_rd(16'hFF04, 1, rd); chk("rst_div", {8'h00, rd}, 16'h0000);
        bus_rd(16'hFF05, 1, rd); chk("rst_tima", {8'h00, rd}, 16'h0000);
        bus_rd(16'hFF06, 1, rd); chk("rst_tma", {8'h00, rd}, 16'h0000);
        bus_rd(16'hFF07, 1, rd); chk("rst_tac", {8'h00, rd}, 16'h00F8);
        chk("rst_req", {15'h0, timer_req}, 16'h0000);

        first_tick = -1;
        tick_cnt   = 0;
        prev_tick  = 1'b0;
        wide_tick  = 1'b0;
        for (int k = 1; k <= 65536; k++) begin
            @(posedge clk);
            #1;
`ifdef GB_TIMER_APU_DIV_TICK_EN
            if (apu_div_tick) begin
                if (first_tick < 0) first_tick = k;
                if (prev_tick) wide_tick = 1'b1;
                if (k % 8192 == 0) tick_cnt++;
                else tick_cnt = tick_cnt - 100;
            end
            prev_tick = apu_div_tick;
`endif
            if (k == 256) begin
                bus_rd(16'hFF04, 1, rd);
                chk("div_256", {8'h00, rd}, 16'h0001);
            end
            if (k == 65535) begin
                bus_rd(16'hFF04, 1, rd);
                chk("div_65535", {8'h00, rd}, 16'h00FF);
            end
            if (k == 65536) begin
                bus_rd(16'hFF04, 1, rd);
                chk("div_wrap", {8'h00, rd}, 16'h0000);
            end
        end
`ifdef GB_TIMER_APU_DIV_TICK_EN
        chk("apu_first", first_tick[15:0], 16'd8192);
        chk("apu_count", tick_cnt[15:0], 16'd8);
        chk("apu_width", {15'h0, wide_tick}, 16'h0000);
`endif

        foreach (vq[i]) begin
            if (vq[i].wr) bus_wr(vq[i].waddr, vq[i].wdata);
            adv(vq[i].adv);
            bus_rd(vq[i].raddr, vq[i].ren, rd);
            chk($sformatf("vec%0d_rd", i), {8'h00, rd},
                {8'h00, vq[i].exp_rd});
            chk($sformatf("vec%0d_req", i), {15'h0, timer_req},
                {15'h0, vq[i].exp_req});
        end

        // reset one clk into the overflow delay
        adv(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rstdly_req%0d", i), {15'h0, timer_req}, 16'h0);
            bus_rd(16'hFF05, 1, rd);
            chk($sformatf("rstdly_tima%0d", i), {8'h00, rd}, 16'h0000);
            adv(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
